// File: rtl/nla_pkg.sv
// Shared types and defaults for the non-linear approximation engine.
package nla_pkg;
  localparam int          DEF_RAM_WIDTH  = 32;
  localparam int          DEF_ADDR_LINES = 4;
  localparam logic [31:0] DEF_START_WORD = 32'h7F90_0000;

  typedef enum logic [2:0] {
    IDLE, LOAD, READY, READ, DRAIN, REWIND
  } seq_state_e;
endpackage

// File: rtl/coeff_rd_delay.sv
// Aligns read valid/index with FIFO read data across RD_LAT register stages.
module coeff_rd_delay #(
  parameter int RD_LAT = 1,
  parameter int IW     = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          vld_i,
  input  logic [IW-1:0] idx_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);
  logic [RD_LAT-1:0]         vld_q;
  logic [RD_LAT-1:0][IW-1:0] idx_q;
  logic [RD_LAT:0]           vld_pipe;
  logic [RD_LAT:0][IW-1:0]   idx_pipe;

  assign vld_pipe = {vld_q, vld_i};
  assign idx_pipe = {idx_q, idx_i};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_pipe[RD_LAT-1:0];
      idx_q <= idx_pipe[RD_LAT-1:0];
    end
  end

  assign vld_o = vld_pipe[RD_LAT];
  assign idx_o = idx_pipe[RD_LAT];
endmodule

// File: rtl/coeff_seq_ctrl.sv
// Frames host coefficient uploads into the FIFO and replays the stored set
// once per evaluation request, rewinding the FIFO read pointer after each pass.
module coeff_seq_ctrl
  import nla_pkg::*;
#(
  parameter int                   RAM_WIDTH  = DEF_RAM_WIDTH,
  parameter int                   ADDR_LINES = DEF_ADDR_LINES,
  parameter logic [RAM_WIDTH-1:0] START_WORD = RAM_WIDTH'(DEF_START_WORD),
  parameter int                   RD_LAT     = 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  s_valid_i,
  input  logic [RAM_WIDTH-1:0]  s_data_i,
  output logic                  s_ready_o,
  input  logic                  eval_req_i,
  output logic                  coeff_valid_o,
  output logic [RAM_WIDTH-1:0]  coeff_data_o,
  output logic [ADDR_LINES-1:0] coeff_idx_o,
  output logic                  eval_done_o,
  output logic                  fifo_wr_en_o,
  output logic [RAM_WIDTH-1:0]  fifo_data_o,
  output logic                  fifo_rd_en_o,
  output logic                  fifo_redo_o,
  input  logic                  fifo_full_i,
  input  logic [RAM_WIDTH-1:0]  fifo_data_i,
  output logic [ADDR_LINES:0]   ncoeff_o,
  output logic                  loaded_o,
  output logic                  err_o
);
  localparam int AW = ADDR_LINES;
  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  seq_state_e    state_q;
  logic [AW:0]   count_q;
  logic [AW-1:0] rd_idx_q;
  logic [7:0]    drain_q;
  logic          pending_q;
  logic          is_start, room, busy;

  assign is_start     = (s_data_i == START_WORD);
  assign room         = (count_q != DEPTH) && !fifo_full_i;
  assign busy         = (state_q == READ) || (state_q == DRAIN) || (state_q == REWIND);
  assign s_ready_o    = (state_q == IDLE) || (state_q == LOAD);
  assign fifo_wr_en_o = (state_q == LOAD) && s_valid_i && !is_start && room;
  assign fifo_data_o  = fifo_wr_en_o ? s_data_i : '0;
  assign fifo_rd_en_o = (state_q == READ);
  assign fifo_redo_o  = (state_q == REWIND);
  assign eval_done_o  = (state_q == REWIND);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rd_idx_q  <= '0;
      drain_q   <= '0;
      pending_q <= 1'b0;
      ncoeff_o  <= '0;
      loaded_o  <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      if (busy && eval_req_i) pending_q <= 1'b1;
      case (state_q)
        IDLE: if (s_valid_i && is_start) begin
          state_q <= LOAD;
          count_q <= '0;
        end
        LOAD: if (s_valid_i) begin
          if (is_start) begin
            if (count_q != '0) begin
              state_q  <= READY;
              ncoeff_o <= count_q;
              loaded_o <= 1'b1;
            end else begin
              state_q <= IDLE;
              err_o   <= 1'b1;
            end
          end else if (room) count_q <= count_q + 1'b1;
          else err_o <= 1'b1;
        end
        READY: if (eval_req_i || pending_q) begin
          state_q   <= READ;
          pending_q <= 1'b0;
          rd_idx_q  <= '0;
        end
        READ: begin
          rd_idx_q <= rd_idx_q + 1'b1;
          if ({1'b0, rd_idx_q} == ncoeff_o - 1'b1) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end
        end
        // Hold off the rewind until the last read word has left the delay line.
        DRAIN: begin
          drain_q <= drain_q + 1'b1;
          if (drain_q == 8'(RD_LAT-1)) state_q <= REWIND;
        end
        REWIND: state_q <= READY;
        default: state_q <= IDLE;
      endcase
    end
  end

  coeff_rd_delay #(.RD_LAT(RD_LAT), .IW(AW)) u_rd_delay (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .vld_i  (fifo_rd_en_o),
    .idx_i  (rd_idx_q),
    .vld_o  (coeff_valid_o),
    .idx_o  (coeff_idx_o)
  );

  assign coeff_data_o = coeff_valid_o ? fifo_data_i : '0;
endmodule

// File: tb/tb_coeff_seq_ctrl.sv
// Directed bench for coeff_seq_ctrl with a behavioural FIFO and scoreboards.
module tb_coeff_seq_ctrl;
  localparam int RW = 32, AW = 4, RD_LAT = 1, DEPTH = 16;
  localparam logic [31:0] SW = 32'h7F90_0000;

  logic          clk = 0, rstn = 0;
  logic          s_valid = 0, eval_req = 0, s_ready;
  logic [RW-1:0] s_data = '0;
  logic          coeff_valid, eval_done, wr_en, rd_en, redo, full, loaded, err;
  logic [RW-1:0] coeff_data, fifo_wdata, fifo_rdata;
  logic [AW-1:0] coeff_idx;
  logic [AW:0]   ncoeff;

  coeff_seq_ctrl #(.RAM_WIDTH(RW), .ADDR_LINES(AW), .START_WORD(SW), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk), .rstn_i(rstn), .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
    .eval_req_i(eval_req), .coeff_valid_o(coeff_valid), .coeff_data_o(coeff_data),
    .coeff_idx_o(coeff_idx), .eval_done_o(eval_done), .fifo_wr_en_o(wr_en),
    .fifo_data_o(fifo_wdata), .fifo_rd_en_o(rd_en), .fifo_redo_o(redo), .fifo_full_i(full),
    .fifo_data_i(fifo_rdata), .ncoeff_o(ncoeff), .loaded_o(loaded), .err_o(err));

  always #5 clk = ~clk;

  // Behavioural FIFO: one-cycle read latency, redo rewinds the read pointer.
  logic [RW-1:0] mem [DEPTH];
  int wp, rp;
  assign full = (wp == DEPTH);
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= 0; rp <= 0; fifo_rdata <= '0;
    end else begin
      if (wr_en) begin mem[wp] <= fifo_wdata; wp <= wp + 1; end
      if (rd_en) begin fifo_rdata <= mem[rp]; rp <= rp + 1; end
      if (redo) rp <= 0;
    end
  end

  int n_chk = 0, n_pass = 0, cyc = 0;
  int wr_cnt, done_cnt, vextra, wextra, req_cyc;
  logic [35:0] sb[$];
  logic [31:0] wq[$];
  int done_cyc[$], vstart[$];
  logic [31:0] coef [3] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      if (wq.size() == 0) wextra++;
      else chk("wr_data", 64'(fifo_wdata), 64'(wq.pop_front()));
    end
    if (coeff_valid) begin
      if (coeff_idx == '0) vstart.push_back(cyc);
      if (sb.size() == 0) vextra++;
      else chk("coeff", 64'({coeff_idx, coeff_data}), 64'(sb.pop_front()));
    end
    if (redo) chk("redo_vs_rd", 64'(rd_en), 64'(0));
    if (eval_done) begin done_cnt++; done_cyc.push_back(cyc); end
  end

  task automatic clr();
    sb.delete(); wq.delete(); done_cyc.delete(); vstart.delete();
    wr_cnt = 0; done_cnt = 0; vextra = 0; wextra = 0;
  endtask

  task automatic do_reset();
    rstn = 0; s_valid = 0; eval_req = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    clr();
  endtask

  task automatic send(input logic [31:0] w);
    s_valid = 1; s_data = w;
    @(posedge clk); #1;
    s_valid = 0; s_data = '0;
  endtask

  task automatic load3();
    send(SW);
    for (int i = 0; i < 3; i++) begin wq.push_back(coef[i]); send(coef[i]); end
    send(SW);
  endtask

  task automatic req(input bit expect_pass);
    if (expect_pass) for (int i = 0; i < 3; i++) sb.push_back({4'(i), coef[i]});
    eval_req = 1; req_cyc = cyc;
    @(posedge clk); #1;
    eval_req = 0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 200) begin @(posedge clk); n++; end
    #1 chk(tag, 64'(done_cnt >= target), 64'(1));
  endtask

  initial begin
    do_reset();
    rstn = 0; #2;
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    chk("rst_outs", 64'({coeff_valid, eval_done, wr_en, rd_en, redo, loaded, err}), 64'(0));
    chk("rst_ncoeff", 64'(ncoeff), 64'(0));
    @(posedge clk); #1 rstn = 1;
    @(posedge clk); #1;

    // Load a three-word frame
    load3();
    chk("load_ncoeff", 64'(ncoeff), 64'(3));
    chk("load_flags", 64'({loaded, err, s_ready}), 64'(3'b100));
    chk("load_wr_cnt", 64'(wr_cnt), 64'(3));

    // Single pass with timing, then identical replay
    req(1);
    wait_done(1, "pass1_done");
    chk("pass1_lat", 64'(done_cyc[0] - req_cyc), 64'(3 + RD_LAT + 1));
    chk("pass1_vstart", 64'(vstart[0] - req_cyc), 64'(1 + RD_LAT));
    chk("pass1_sb", 64'(sb.size()), 64'(0));
    req(1);
    wait_done(2, "pass2_done");
    chk("pass2_sb", 64'({sb.size(), vextra}), 64'(0));

    // Back-to-back: second request during READ, third dropped
    clr();
    req(1);
    req(1);
    req(0);
    wait_done(2, "b2b_done");
    repeat (12) @(posedge clk); #1;
    chk("b2b_done_cnt", 64'(done_cnt), 64'(2));
    chk("b2b_start", 64'(vstart[1] - done_cyc[0]), 64'(2 + RD_LAT));
    chk("b2b_extra", 64'({sb.size(), vextra, wextra}), 64'(0));

    // Overflow: 17 data words into a 16-deep set
    do_reset();
    send(SW);
    for (int i = 0; i < 17; i++) begin
      if (i < DEPTH) wq.push_back(32'h1000 + i);
      send(32'h1000 + i);
    end
    send(SW);
    chk("ovf_wr_cnt", 64'(wr_cnt), 64'(16));
    chk("ovf_ncoeff", 64'(ncoeff), 64'(16));
    chk("ovf_flags", 64'({loaded, err}), 64'(2'b11));

    // Empty frame
    do_reset();
    send(SW);
    send(SW);
    chk("empty_flags", 64'({loaded, err, s_ready}), 64'(3'b011));
    chk("empty_wr_cnt", 64'(wr_cnt), 64'(0));

    // Reset in the middle of a READ
    do_reset();
    load3();
    req(1);
    @(posedge clk); #1;
    chk("mid_in_read", 64'(rd_en), 64'(1));
    rstn = 0; #1;
    chk("mid_rst_outs", 64'({coeff_valid, eval_done, wr_en, rd_en, redo, loaded, err}), 64'(0));
    chk("mid_rst_ready", 64'({s_ready, ncoeff}), 64'({1'b1, 5'd0}));
    @(posedge clk); #1 rstn = 1;
    clr();
    repeat (10) @(posedge clk); #1;
    chk("mid_no_valid", 64'(vextra), 64'(0));
    chk("mid_idle", 64'({s_ready, loaded}), 64'(2'b10));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
